// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - CPU load/store front end to a word-wide data memory; `define MEM_ACCESS_SUBWORD_EN adds byte/half access via read-modify-write
module mem_access_ctrl #(
  parameter int MEM_WORDS = 64,
  parameter int RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    WRITE,
`ifdef MEM_ACCESS_SUBWORD_EN
    RMW_RD,
    RMW_WR,
`endif
    RESP
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [3:0]  lat_cnt;
  logic        lat_done;
  logic        accept;
  logic        req_bad;
  logic [31:0] ld_data;

`ifdef MEM_ACCESS_SUBWORD_EN
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic [31:0] merged;
`endif

  assign lat_done = (lat_cnt == 4'd1);

  // Classify the incoming request: anything that must not touch memory is an error.
  always_comb begin
    req_bad = 1'b0;
    if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS)) begin
      req_bad = 1'b1;
    end
    case (req_size)
      2'b10: if (req_addr[1:0] != 2'b00) req_bad = 1'b1;
`ifdef MEM_ACCESS_SUBWORD_EN
      2'b01: if (req_addr[0]) req_bad = 1'b1;
      2'b00: ;
`else
      2'b01: req_bad = 1'b1;
      2'b00: req_bad = 1'b1;
`endif
      default: req_bad = 1'b1;
    endcase
  end

`ifdef MEM_ACCESS_SUBWORD_EN
  // Lane extraction for loads and lane insertion for read-modify-write stores;
  // mem_wdata still holds the right-aligned store data while in RMW_RD.
  always_comb begin
    ld_data = mem_rdata;
    merged  = mem_rdata;
    case (size_q)
      2'b00: begin
        ld_data = {24'h0, mem_rdata[{lane_q, 3'b000} +: 8]};
        merged[{lane_q, 3'b000} +: 8] = mem_wdata[7:0];
      end
      2'b01: begin
        ld_data = {16'h0, mem_rdata[{lane_q[1], 4'b0000} +: 16]};
        merged[{lane_q[1], 4'b0000} +: 16] = mem_wdata[15:0];
      end
      default: ;
    endcase
  end
`else
  assign ld_data = mem_rdata;
`endif

  // State register; reset aborts any access and drops the strobes at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and the strobes/handshakes that depend only on state.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    accept     = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (req_bad) begin
            next_state = RESP;
          end else if (!req_we) begin
            next_state = RD_WAIT;
`ifdef MEM_ACCESS_SUBWORD_EN
          end else if (req_size != 2'b10) begin
            next_state = RMW_RD;
`endif
          end else begin
            next_state = WRITE;
          end
        end
      end
      RD_WAIT: begin
        MemRead = 1'b1;
        if (lat_done) next_state = RESP;
      end
      WRITE: begin
        MemWrite   = 1'b1;
        next_state = RESP;
      end
`ifdef MEM_ACCESS_SUBWORD_EN
      RMW_RD: begin
        MemRead = 1'b1;
        if (lat_done) next_state = RMW_WR;
      end
      RMW_WR: begin
        MemWrite   = 1'b1;
        next_state = RESP;
      end
`endif
      RESP: begin
        rsp_valid  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request latching, read-latency countdown and response data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt   <= 4'd0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
`ifdef MEM_ACCESS_SUBWORD_EN
      size_q    <= 2'b10;
      lane_q    <= 2'b00;
`endif
    end else begin
      if (accept) begin
        mem_addr  <= {2'b00, req_addr[31:2]};
        mem_wdata <= req_wdata;
        lat_cnt   <= 4'(RD_LAT);
`ifdef MEM_ACCESS_SUBWORD_EN
        size_q    <= req_size;
        lane_q    <= req_addr[1:0];
`endif
        if (req_bad) begin
          rsp_rdata <= 32'h0;
          rsp_err   <= 1'b1;
        end
      end
      case (state)
        RD_WAIT: begin
          if (lat_done) begin
            lat_cnt   <= 4'd0;
            rsp_rdata <= ld_data;
            rsp_err   <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
`ifdef MEM_ACCESS_SUBWORD_EN
        RMW_RD: begin
          if (lat_done) begin
            lat_cnt   <= 4'd0;
            mem_wdata <= merged;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        RMW_WR: begin
          rsp_rdata <= 32'h0;
          rsp_err   <= 1'b0;
        end
`endif
        WRITE: begin
          rsp_rdata <= 32'h0;
          rsp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed bench for mem_access_ctrl at RD_LAT=1 and RD_LAT=3 sharing one memory model
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [1:0]  req_size = 2'b10;
  logic [31:0] mem_rdata;
  logic        sel = 1'b0;

  logic        a_valid, b_valid;
  logic        a_ready, b_ready, a_rsp_valid, b_rsp_valid, a_rsp_err, b_rsp_err;
  logic [31:0] a_rsp_rdata, b_rsp_rdata, a_mem_addr, b_mem_addr, a_mem_wdata, b_mem_wdata;
  logic        a_rd, b_rd, a_wr, b_wr;

  assign a_valid = req_valid & ~sel;
  assign b_valid = req_valid & sel;

  mem_access_ctrl #(.MEM_WORDS(64), .RD_LAT(1)) u_dut_lat1 (
    .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(a_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .MemRead(a_rd), .MemWrite(a_wr),
    .mem_rdata(mem_rdata)
  );

  mem_access_ctrl #(.MEM_WORDS(64), .RD_LAT(3)) u_dut_lat3 (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .MemRead(b_rd), .MemWrite(b_wr),
    .mem_rdata(mem_rdata)
  );

  logic        s_ready, s_rsp_valid, s_rsp_err, s_rd, s_wr;
  logic [31:0] s_rsp_rdata, s_mem_addr, s_mem_wdata;
  assign s_ready     = sel ? b_ready     : a_ready;
  assign s_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign s_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
  assign s_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
  assign s_mem_addr  = sel ? b_mem_addr  : a_mem_addr;
  assign s_mem_wdata = sel ? b_mem_wdata : a_mem_wdata;
  assign s_rd        = sel ? b_rd        : a_rd;
  assign s_wr        = sel ? b_wr        : a_wr;

  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (s_wr && s_mem_addr < 32'd64) mem[s_mem_addr[5:0]] <= s_mem_wdata;
  end
  assign mem_rdata = (s_rd && s_mem_addr < 32'd64) ? mem[s_mem_addr[5:0]] : 32'h0;

  int checks = 0;
  int errors = 0;

  int          o_rd_cnt, o_rd_first, o_wr_cnt, o_wr_cyc, o_resp_cyc;
  logic [31:0] o_wr_data, o_rdata;
  logic        o_err, o_both, o_addr_bad, o_ready_busy, o_acc_ready;

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size);
    o_rd_cnt = 0; o_rd_first = 0; o_wr_cnt = 0; o_wr_cyc = 0; o_resp_cyc = 0;
    o_wr_data = 32'h0; o_rdata = 32'hFFFF_FFFF; o_err = 1'bx;
    o_both = 1'b0; o_addr_bad = 1'b0; o_ready_busy = 1'b0;
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; req_valid = 1'b1;
    o_acc_ready = s_ready;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (s_rd) begin
        o_rd_cnt++;
        if (o_rd_first == 0) o_rd_first = k;
      end
      if (s_wr) begin
        o_wr_cnt++;
        o_wr_cyc = k;
        o_wr_data = s_mem_wdata;
      end
      if (s_rd && s_wr) o_both = 1'b1;
      if ((s_rd || s_wr) && s_mem_addr != {2'b00, addr[31:2]}) o_addr_bad = 1'b1;
      if (s_ready && !s_rsp_valid) o_ready_busy = 1'b1;
      if (s_rsp_valid) begin
        o_resp_cyc = k;
        o_rdata = s_rsp_rdata;
        o_err = s_rsp_err;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err, a_mem_addr, a_mem_wdata, a_rd, a_wr} !==
        {1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_lat1: ready=%b vld=%b rdata=%h err=%b addr=%h wdata=%h rd=%b wr=%b required 1 0 0 0 0 0 0 0",
               a_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err, a_mem_addr, a_mem_wdata, a_rd, a_wr);
    end
    checks++;
    if ({b_ready, b_rsp_valid, b_rsp_rdata, b_rsp_err, b_mem_addr, b_mem_wdata, b_rd, b_wr} !==
        {1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_lat3: ready=%b vld=%b rdata=%h err=%b addr=%h wdata=%h rd=%b wr=%b required 1 0 0 0 0 0 0 0",
               b_ready, b_rsp_valid, b_rsp_rdata, b_rsp_err, b_mem_addr, b_mem_wdata, b_rd, b_wr);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_ready, a_rsp_valid, a_rd, a_wr} !== 4'b1000) begin
      errors++;
      $display("FAIL idle_after_reset: ready/vld/rd/wr=%b required 1000", {a_ready, a_rsp_valid, a_rd, a_wr});
    end
  endtask

  task automatic test_load_word;
    sel = 1'b0;
    issue(1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 2'b10);
    issue(1'b0, 32'h0000_0008, 32'h0, 2'b10);
    checks++;
    if ({o_acc_ready, o_rd_first, o_rd_cnt, o_wr_cnt, o_resp_cyc} !== {1'b1, 32'd1, 32'd1, 32'd0, 32'd2}) begin
      errors++;
      $display("FAIL load_word_timing: ready=%b rd_first=%0d rd_cnt=%0d wr_cnt=%0d resp=%0d required 1 1 1 0 2",
               o_acc_ready, o_rd_first, o_rd_cnt, o_wr_cnt, o_resp_cyc);
    end
    checks++;
    if ({o_rdata, o_err, o_addr_bad, o_both, o_ready_busy} !== {32'hDEAD_BEEF, 4'b0000}) begin
      errors++;
      $display("FAIL load_word_data: rdata=%h err=%b addr_bad=%b both=%b ready_busy=%b required deadbeef 0 0 0 0",
               o_rdata, o_err, o_addr_bad, o_both, o_ready_busy);
    end
  endtask

  task automatic test_store_word;
    sel = 1'b0;
    issue(1'b1, 32'h0000_00FC, 32'h1234_5678, 2'b10);
    checks++;
    if ({o_wr_cnt, o_wr_cyc, o_rd_cnt, o_resp_cyc} !== {32'd1, 32'd1, 32'd0, 32'd2}) begin
      errors++;
      $display("FAIL store_word_timing: wr_cnt=%0d wr_cyc=%0d rd_cnt=%0d resp=%0d required 1 1 0 2",
               o_wr_cnt, o_wr_cyc, o_rd_cnt, o_resp_cyc);
    end
    checks++;
    if ({o_wr_data, o_rdata, o_err, o_addr_bad, o_both} !== {32'h1234_5678, 32'h0, 3'b000}) begin
      errors++;
      $display("FAIL store_word_data: wdata=%h rdata=%h err=%b addr_bad=%b both=%b required 12345678 0 0 0 0",
               o_wr_data, o_rdata, o_err, o_addr_bad, o_both);
    end
    issue(1'b0, 32'h0000_00FC, 32'h0, 2'b10);
    checks++;
    if ({o_rdata, o_err, o_resp_cyc} !== {32'h1234_5678, 1'b0, 32'd2}) begin
      errors++;
      $display("FAIL store_readback: rdata=%h err=%b resp=%0d required 12345678 0 2", o_rdata, o_err, o_resp_cyc);
    end
    @(negedge clk);
    checks++;
    if ({s_rsp_valid, s_rsp_rdata, s_rsp_err} !== {1'b0, 32'h1234_5678, 1'b0}) begin
      errors++;
      $display("FAIL rsp_hold: vld=%b rdata=%h err=%b required 0 12345678 0", s_rsp_valid, s_rsp_rdata, s_rsp_err);
    end
  endtask

  task automatic test_errors;
    logic [31:0] addrs [4] = '{32'h0000_0100, 32'h0000_0006, 32'h0000_0004, 32'h0000_0000};
    logic [1:0]  sizes [4] = '{2'b10, 2'b10, 2'b11, 2'b11};
    logic        wes   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(wes[i], addrs[i], 32'h5555_5555, sizes[i]);
      checks++;
      if ({o_resp_cyc, o_err, o_rdata, o_rd_cnt, o_wr_cnt} !== {32'd1, 1'b1, 32'h0, 32'd0, 32'd0}) begin
        errors++;
        $display("FAIL error_req%0d: resp=%0d err=%b rdata=%h rd_cnt=%0d wr_cnt=%0d required 1 1 0 0 0",
                 i, o_resp_cyc, o_err, o_rdata, o_rd_cnt, o_wr_cnt);
      end
    end
    @(negedge clk);
    checks++;
    if ({s_rsp_valid, s_rsp_err} !== 2'b01) begin
      errors++;
      $display("FAIL err_hold: vld=%b err=%b required 0 1", s_rsp_valid, s_rsp_err);
    end
  endtask

  task automatic test_latency3;
    sel = 1'b1;
    issue(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 2'b10);
    checks++;
    if ({o_wr_cyc, o_wr_cnt, o_resp_cyc, o_err} !== {32'd1, 32'd1, 32'd2, 1'b0}) begin
      errors++;
      $display("FAIL lat3_store: wr_cyc=%0d wr_cnt=%0d resp=%0d err=%b required 1 1 2 0", o_wr_cyc, o_wr_cnt, o_resp_cyc, o_err);
    end
    issue(1'b0, 32'h0000_0010, 32'h0, 2'b10);
    checks++;
    if ({o_rd_first, o_rd_cnt, o_wr_cnt, o_resp_cyc, o_rdata, o_err, o_addr_bad, o_ready_busy} !==
        {32'd1, 32'd3, 32'd0, 32'd4, 32'hCAFE_F00D, 3'b000}) begin
      errors++;
      $display("FAIL lat3_load: rd_first=%0d rd_cnt=%0d wr_cnt=%0d resp=%0d rdata=%h err=%b addr_bad=%b busy_ready=%b required 1 3 0 4 cafef00d 0 0 0",
               o_rd_first, o_rd_cnt, o_wr_cnt, o_resp_cyc, o_rdata, o_err, o_addr_bad, o_ready_busy);
    end
    issue(1'b0, 32'h0000_00FC, 32'h0, 2'b10);
    checks++;
    if ({o_rd_cnt, o_resp_cyc, o_rdata, o_err} !== {32'd3, 32'd4, 32'h1234_5678, 1'b0}) begin
      errors++;
      $display("FAIL lat3_last_word: rd_cnt=%0d resp=%0d rdata=%h err=%b required 3 4 12345678 0", o_rd_cnt, o_resp_cyc, o_rdata, o_err);
    end
    issue(1'b1, 32'h0000_0100, 32'h0, 2'b10);
    checks++;
    if ({o_resp_cyc, o_err, o_wr_cnt, o_rd_cnt} !== {32'd1, 1'b1, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL lat3_oob_store: resp=%0d err=%b wr_cnt=%0d rd_cnt=%0d required 1 1 0 0", o_resp_cyc, o_err, o_wr_cnt, o_rd_cnt);
    end
  endtask

  task automatic test_subword;
    sel = 1'b0;
    issue(1'b1, 32'h0000_0004, 32'hAABB_CCDD, 2'b10);
`ifdef MEM_ACCESS_SUBWORD_EN
    issue(1'b1, 32'h0000_0005, 32'h0000_0011, 2'b00);
    checks++;
    if ({o_rd_first, o_rd_cnt, o_wr_cyc, o_wr_cnt, o_wr_data, o_resp_cyc, o_err, o_both} !==
        {32'd1, 32'd1, 32'd2, 32'd1, 32'hAABB_11DD, 32'd3, 2'b00}) begin
      errors++;
      $display("FAIL rmw_byte: rd_first=%0d rd_cnt=%0d wr_cyc=%0d wr_cnt=%0d wdata=%h resp=%0d err=%b both=%b required 1 1 2 1 aabb11dd 3 0 0",
               o_rd_first, o_rd_cnt, o_wr_cyc, o_wr_cnt, o_wr_data, o_resp_cyc, o_err, o_both);
    end
    issue(1'b0, 32'h0000_0006, 32'h0, 2'b01);
    checks++;
    if ({o_rdata, o_err, o_resp_cyc} !== {32'h0000_AABB, 1'b0, 32'd2}) begin
      errors++;
      $display("FAIL load_half: rdata=%h err=%b resp=%0d required 0000aabb 0 2", o_rdata, o_err, o_resp_cyc);
    end
    issue(1'b0, 32'h0000_0004, 32'h0, 2'b00);
    checks++;
    if ({o_rdata, o_err} !== {32'h0000_00DD, 1'b0}) begin
      errors++;
      $display("FAIL load_byte: rdata=%h err=%b required 000000dd 0", o_rdata, o_err);
    end
    issue(1'b0, 32'h0000_0005, 32'h0, 2'b01);
    checks++;
    if ({o_resp_cyc, o_err, o_rd_cnt} !== {32'd1, 1'b1, 32'd0}) begin
      errors++;
      $display("FAIL half_misaligned: resp=%0d err=%b rd_cnt=%0d required 1 1 0", o_resp_cyc, o_err, o_rd_cnt);
    end
    sel = 1'b1;
    issue(1'b1, 32'h0000_0006, 32'h0000_5566, 2'b01);
    checks++;
    if ({o_rd_cnt, o_wr_cyc, o_wr_data, o_resp_cyc} !== {32'd3, 32'd4, 32'h5566_11DD, 32'd5}) begin
      errors++;
      $display("FAIL lat3_rmw_half: rd_cnt=%0d wr_cyc=%0d wdata=%h resp=%0d required 3 4 556611dd 5",
               o_rd_cnt, o_wr_cyc, o_wr_data, o_resp_cyc);
    end
`else
    issue(1'b0, 32'h0000_0005, 32'h0, 2'b00);
    checks++;
    if ({o_resp_cyc, o_err, o_rdata, o_rd_cnt} !== {32'd1, 1'b1, 32'h0, 32'd0}) begin
      errors++;
      $display("FAIL byte_load_disabled: resp=%0d err=%b rdata=%h rd_cnt=%0d required 1 1 0 0", o_resp_cyc, o_err, o_rdata, o_rd_cnt);
    end
    issue(1'b1, 32'h0000_0006, 32'h0000_5566, 2'b01);
    checks++;
    if ({o_resp_cyc, o_err, o_rd_cnt, o_wr_cnt} !== {32'd1, 1'b1, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL half_store_disabled: resp=%0d err=%b rd_cnt=%0d wr_cnt=%0d required 1 1 0 0", o_resp_cyc, o_err, o_rd_cnt, o_wr_cnt);
    end
    issue(1'b0, 32'h0000_0004, 32'h0, 2'b10);
    checks++;
    if (o_rdata !== 32'hAABB_CCDD) begin
      errors++;
      $display("FAIL word_untouched: rdata=%h required aabbccdd", o_rdata);
    end
`endif
  endtask

  task automatic test_back_to_back;
    logic [31:0] vals [3] = '{32'h0101_0101, 32'h7F00_00FE, 32'hFFFF_0000};
    sel = 1'b0;
    for (int i = 0; i < 3; i++) issue(1'b1, 32'h20 + 32'(i * 4), vals[i], 2'b10);
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 32'h20 + 32'(i * 4), 32'h0, 2'b10);
      checks++;
      if ({o_acc_ready, o_ready_busy, o_rdata, o_resp_cyc} !== {2'b10, vals[i], 32'd2}) begin
        errors++;
        $display("FAIL b2b_load%0d: ready=%b busy_ready=%b rdata=%h resp=%0d required 1 0 %h 2",
                 i, o_acc_ready, o_ready_busy, o_rdata, o_resp_cyc, vals[i]);
      end
    end
  endtask

  task automatic test_reset_abort;
    int seen;
    sel = 1'b1;
    seen = 0;
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h0000_0010; req_size = 2'b10; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (s_rd !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre_rd: MemRead=%b required 1", s_rd);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({s_rd, s_wr, s_ready, s_rsp_valid} !== 4'b0010) begin
      errors++;
      $display("FAIL abort_immediate: rd/wr/ready/vld=%b required 0010", {s_rd, s_wr, s_ready, s_rsp_valid});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (s_rsp_valid || s_rd) seen++;
    end
    checks++;
    if ({seen, s_ready} !== {32'd0, 1'b1}) begin
      errors++;
      $display("FAIL abort_no_resp: activity=%0d ready=%b required 0 1", seen, s_ready);
    end
  endtask

  initial begin
    test_reset;
    test_load_word;
    test_store_word;
    test_errors;
    test_latency3;
    test_subword;
    test_back_to_back;
    test_reset_abort;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
